pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised pipeline stage register that generalises the fixed IF/ID register into a reusable stage for every boundary of the pipelined CPU (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an arbitrary-width payload with a valid/ready handshake, so stalls propagate without losing instructions. A synchronous flush inserts a bubble for branch and exception squashes. An optional skid buffer registers `in_ready` to break long stall paths, and a saturating counter records cycles the stage spends stalled.

## Interface
- `DATA_W`, 96, payload width in bits (for example, 32-bit instruction + 64-bit PC).
- `BUBBLE`, `'0`, `DATA_W`-bit value driven on `out_data` when the stage is empty or flushed.
- `CNT_W`, 16, width of the stall counter.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous squash of all held entries.
- `in_valid`  in  1  upstream beat present.
- `in_ready`  out  1  stage can accept a beat.
- `in_data`  in  `DATA_W`  upstream payload.
- `out_valid`  out  1  stage holds a valid beat.
- `out_ready`  in  1  downstream accepts the beat.
- `out_data`  out  `DATA_W`  held payload.
- `stall_cnt`  out  `CNT_W`  saturating count of stalled cycles.

## Operation
- A beat is accepted when `in_valid & in_ready` and consumed when `out_valid & out_ready`, both evaluated at the rising clock edge.
- Reset state (asserted while `reset`=0):
  - `out_valid`=0, `out_data`=`BUBBLE`, `in_ready`=1, `stall_cnt`=0.
  - All internal entries are invalid.
  - Reset applied mid-operation discards all held beats immediately.
- Skid-mode FSM (see Configuration):
  - EMPTY: `out_valid`=0, `in_ready`=1.
    - Accept → FULL, with the beat written to the main register.
  - FULL: `out_valid`=1, `in_ready`=1.
    - Accept and consume in the same cycle → FULL, main register reloads.
    - Accept only → SKID, beat written to the skid register.
    - Consume only → EMPTY.
    - Neither → FULL, main register holds its value.
  - SKID: `out_valid`=1, `in_ready`=0.
    - Consume → FULL, skid register moves to the main register.
    - Otherwise → SKID, both registers hold.
- Ordering is strictly FIFO. No beat is dropped or duplicated except by `flush`.
- `flush`=1 at an edge:
  - Next state is EMPTY, `out_data`=`BUBBLE`.
  - Any beat handshaken in that same cycle is discarded.
  - `flush` takes priority over every transition. Reset takes priority over `flush`.
- `stall_cnt`:
  - Increments on each edge where `out_valid & ~out_ready`.
  - Saturates at 2^`CNT_W`−1 with no wrap.
  - Cleared only by reset; `flush` does not clear it.

## Timing
- Latency: a beat accepted at edge N appears on `out_data` with `out_valid`=1 after edge N, so it is visible during cycle N+1.
- Throughput: 1 beat per cycle when `out_ready` is held at 1.
- With skid enabled:
  - `in_ready` is a registered output with no combinational path from `out_ready`.
  - Capacity is 2 beats.
  - `in_ready` falls one cycle after downstream first stalls while the stage is FULL.
- With skid disabled:
  - `in_ready` = `~out_valid | out_ready` (combinational).
  - Capacity is 1 beat.
  - FSM reduces to EMPTY/FULL.
- `out_data` and `out_valid` always come directly from flops.
- Upstream must hold `in_data` stable while `in_valid & ~in_ready`. The block keeps `out_data` stable while `out_valid & ~out_ready`.

## Configuration
- `PIPE_STAGE_SKID_EN` defined:
  - 2-entry skid buffer with the EMPTY/FULL/SKID FSM.
  - Registered `in_ready`.
- `PIPE_STAGE_SKID_EN` undefined:
  - No skid register; single-entry EMPTY/FULL behaviour.
  - Combinational `in_ready`.
  - Identical cycle latency and ordering; only capacity and `in_ready` timing differ.

## Test plan
- Reset sequence:
  - Hold `reset`=0 for 2 cycles with `in_valid`=1, `in_data`=420 → `out_valid`=0, `out_data`=`BUBBLE`, `in_ready`=1, `stall_cnt`=0.
  - Release `reset` → value 420 appears on `out_data` one cycle after the first accept.
- Streaming: drive values 1..8 on consecutive cycles with `out_ready`=1 → `out_data` shows 1..8 in order, 1-cycle latency, no gaps.
- Back-pressure (skid enabled):
  - Send A, B, C while `out_ready`=0 → `in_ready` drops after B is held in the skid register; C is not accepted; `stall_cnt` increments each cycle.
  - Raise `out_ready` → A, B, C delivered in order.
- Flush:
  - Assert `flush` while in SKID with `in_valid`=1 → next cycle `out_valid`=0, `out_data`=`BUBBLE`, state EMPTY; the flushed and same-cycle beats never appear.
  - `stall_cnt` is unchanged by the flush.
- Saturation: with `CNT_W`=4, hold `out_valid`=1 and `out_ready`=0 for 20 cycles → `stall_cnt` stops at 15.
- Asynchronous reset mid-operation: drop `reset` between clock edges while in FULL → outputs return to their reset values immediately, without waiting for `clk`.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: reusable pipeline boundary register with a valid/ready
// handshake, synchronous flush to a bubble and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN for a 2-entry skid buffer with a registered
// in_ready. Without it the stage holds one entry and in_ready is combinational.
module pipe_stage_reg #(
  parameter int unsigned         DATA_W = 96,
  parameter logic [DATA_W-1:0]   BUBBLE = '0,
  parameter int unsigned         CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   main_q, main_d;
  logic                valid_q, valid_d;
  logic [CNT_W-1:0]    stall_q, stall_d;
  logic                accept, consume;

`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0]   skid_q, skid_d;
  logic                rdy_q, rdy_d;

  assign in_ready = rdy_q;
`else
  assign in_ready = ~valid_q | out_ready;
`endif

  assign accept    = in_valid & in_ready;
  assign consume   = valid_q & out_ready;
  assign out_valid = valid_q;
  assign out_data  = main_q;
  assign stall_cnt = stall_q;

  // Next-state, payload movement and flush override.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_d  = skid_q;
`endif
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = FULL;
          main_d  = in_data;
        end
      end
      FULL: begin
        if (accept && consume) begin
          main_d = in_data;
        end else if (accept) begin
`ifdef PIPE_STAGE_SKID_EN
          state_d = SKID;
          skid_d  = in_data;
`endif
        end else if (consume) begin
          state_d = EMPTY;
          main_d  = BUBBLE;
        end
      end
      SKID: begin
`ifdef PIPE_STAGE_SKID_EN
        if (consume) begin
          state_d = FULL;
          main_d  = skid_q;
          skid_d  = BUBBLE;
        end
`else
        state_d = EMPTY;
        main_d  = BUBBLE;
`endif
      end
      default: begin
        state_d = EMPTY;
        main_d  = BUBBLE;
      end
    endcase

    if (flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE;
`ifdef PIPE_STAGE_SKID_EN
      skid_d  = BUBBLE;
`endif
    end

    // Handshake outputs are registered versions of the next state so they
    // come straight from flops.
    valid_d = (state_d != EMPTY);
`ifdef PIPE_STAGE_SKID_EN
    rdy_d   = (state_d != SKID);
`endif
  end

  // Saturating count of cycles where a held beat is not taken downstream.
  always_comb begin
    stall_d = stall_q;
    if (valid_q && !out_ready && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // State and payload registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE;
      valid_q <= 1'b0;
      stall_q <= '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_q  <= BUBBLE;
      rdy_q   <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
`ifdef PIPE_STAGE_SKID_EN
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
`endif
    end
  end

endmodule
